// File: rtl/aes128_encryptor_if.sv
// Block/key/result bundle for the iterative AES-128 encryptor.
// ENCRYPTOR_DEBUG_PORTS_EN adds the dbg_round / dbg_state observation signals.
interface aes128_encryptor_if;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;
`ifdef ENCRYPTOR_DEBUG_PORTS_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_state;

  modport master (output plaintext, key, input ciphertext, done, dbg_round, dbg_state);
  modport slave  (input plaintext, key, output ciphertext, done, dbg_round, dbg_state);
`else
  modport master (output plaintext, key, input ciphertext, done);
  modport slave  (input plaintext, key, output ciphertext, done);
`endif
endinterface

// File: rtl/aes128_encryptor.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// Optional debug outputs via ENCRYPTOR_DEBUG_PORTS_EN (dbg_round, dbg_state on the interface).
module aes128_encryptor (
  input  logic                 clk,
  input  logic                 rst,
  aes128_encryptor_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] ct;
  logic         done;
  logic [127:0] next_rk;
  logic [127:0] next_st;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 (square-and-multiply), which maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0]  a;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xtime(a[31:24]) ^ xtime(a[23:16]) ^ a[23:16] ^ a[15:8] ^ a[7:0],
        a[31:24] ^ xtime(a[23:16]) ^ xtime(a[15:8]) ^ a[15:8] ^ a[7:0],
        a[31:24] ^ a[23:16] ^ xtime(a[15:8]) ^ xtime(a[7:0]) ^ a[7:0],
        xtime(a[31:24]) ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ xtime(a[7:0])};
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0]  ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  always_comb begin
    next_rk = expand(rk, rcon(round));
    next_st = (round == 4'd10) ? (sub_shift(st) ^ next_rk)
                               : (mix_columns(sub_shift(st)) ^ next_rk);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm   <= IDLE;
      round <= 4'd0;
      st    <= '0;
      rk    <= '0;
      ct    <= '0;
      done  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          st    <= bus.plaintext ^ bus.key;
          rk    <= bus.key;
          round <= 4'd1;
          fsm   <= RUN;
        end
        RUN: begin
          st <= next_st;
          rk <= next_rk;
          // Final round publishes the result; round stays at 10 while parked in DONE.
          if (round == 4'd10) begin
            ct   <= next_st;
            done <= 1'b1;
            fsm  <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: fsm <= DONE;
      endcase
    end
  end

  assign bus.ciphertext = ct;
  assign bus.done       = done;
`ifdef ENCRYPTOR_DEBUG_PORTS_EN
  assign bus.dbg_round  = round;
  assign bus.dbg_state  = st;
`endif

endmodule

// File: tb/tb_aes128_encryptor.sv
// Directed + randomized bench for aes128_encryptor against a byte-array software AES-128 model.
module tb_aes128_encryptor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb [256];

  aes128_encryptor_if bus();

  aes128_encryptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tw;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++) begin
      tw   = w[i/4];
      s[i] = pt[127-8*i -: 8] ^ tw[31-8*(i%4) -: 8];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c+0] = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
          s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end
      end
      for (int i = 0; i < 16; i++) begin
        tw   = w[4*r + i/4];
        s[i] = s[i] ^ tw[31-8*(i%4) -: 8];
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Reset for one edge, release, then follow the 11-edge run, optionally scrambling inputs after load.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input bit perturb);
    rst = 1'b0;
    bus.plaintext = pt;
    bus.key       = k;
    @(posedge clk); #1;
    check({tag, "_rst_done"}, 128'(bus.done), 128'd0);
    check({tag, "_rst_ct"}, bus.ciphertext, 128'd0);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check($sformatf("%s_e%0d_done", tag, e), 128'(bus.done), 128'd0);
      check($sformatf("%s_e%0d_ct", tag, e), bus.ciphertext, 128'd0);
      if (perturb && e == 1) begin
        bus.plaintext = rand128();
        bus.key       = rand128();
      end
    end
    @(posedge clk); #1;
    check({tag, "_done"}, 128'(bus.done), 128'd1);
    check({tag, "_ct"}, bus.ciphertext, exp);
  endtask

  initial begin
    logic [127:0] pt, k, held;
    build_sbox();
    bus.plaintext = '0;
    bus.key       = '0;

    run_block("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    run_block("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
    run_block("zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0);
    check("model_fips_b", aes_ref(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c),
          128'h3925841d02dc09fbdc118597196a0b32);

    pt = 128'h69206c6f766520636f6d706172636821;
    k  = 128'h6d65677361797372617772746f796f75;
    run_block("ascii", pt, k, aes_ref(pt, k), 1'b1);

    for (int n = 0; n < 6; n++) begin
      pt = rand128();
      k  = rand128();
      run_block($sformatf("rand%0d", n), pt, k, aes_ref(pt, k), n[0]);
    end

    // Abort at edge 5 of a run, then start over with fresh inputs.
    rst = 1'b0;
    bus.plaintext = rand128();
    bus.key       = rand128();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_done", 128'(bus.done), 128'd0);
    check("abort_ct", bus.ciphertext, 128'd0);
    pt = rand128();
    k  = rand128();
    run_block("after_abort", pt, k, aes_ref(pt, k), 1'b0);

    // Park in DONE with inputs toggling every cycle.
    held = aes_ref(pt, k);
    for (int c = 0; c < 100; c++) begin
      bus.plaintext = rand128();
      bus.key       = rand128();
      @(posedge clk); #1;
      check($sformatf("hold%0d_done", c), 128'(bus.done), 128'd1);
      check($sformatf("hold%0d_ct", c), bus.ciphertext, held);
    end

    rst = 1'b0;
    @(posedge clk); #1;
    check("done_rst_done", 128'(bus.done), 128'd0);
    check("done_rst_ct", bus.ciphertext, 128'd0);
    @(posedge clk); #1;
    check("idle_stay_done", 128'(bus.done), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
